jump_flag_serializer: RTL and testbench

Downstream consumer of the jump-flag result byte produced beside the execute stage. It accepts 8-bit flag bytes through a valid/ready handshake and buffers them in a small FIFO. It then serializes each byte onto a single-wire UART-style line (start bit, 8 data bits LSB first, stop bit) at a fixed bit period. It reports busy while any byte is queued or in flight.

---
 rtl/jump_flag_serializer_pkg.sv | 18 +
 rtl/jump_flag_fifo.sv | 58 +++++
 rtl/jump_flag_serializer.sv | 153 +++++++++++++++
 tb/tb_jump_flag_serializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_flag_serializer_pkg.sv
// Shared encodings for the jump-flag serializer: FSM states, idle line level, reset polarity.
// The PARITY encoding is only reachable when JUMP_FLAG_PARITY_EN is defined.
package jump_flag_serializer_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic RstEnable = 1'b1;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/jump_flag_fifo.sv
// Synchronous FIFO with wrap-bit pointers; dout_o shows the head combinationally.
// Zero-latency read, one-cycle write; push ignored when full, pop ignored when empty.
module jump_flag_fifo
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);
   import jump_flag_serializer_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   // Both gates look at pre-edge state, so a full FIFO refuses a push even while popping.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/jump_flag_serializer.sv
// Serializes buffered jump-flag bytes onto a UART-style line; optional even parity via JUMP_FLAG_PARITY_EN.
// Byte accepted at edge N is popped at N+1 and its start bit appears at N+2; frames run back to back.
// ready_o is simply !full; upstream holds valid_i/data_i until it is accepted.
module jump_flag_serializer
#(
   parameter int BIT_CYCLES = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid_i,
   input  logic [7:0] data_i,
   output logic       ready_o,
   output logic       tx_o,
   output logic       busy_o
);
   import jump_flag_serializer_pkg::*;

   localparam logic [15:0] BAUD_LAST = 16'(BIT_CYCLES - 1);

   logic [2:0]  state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        baud_wrap;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  fifo_dout;
`ifdef JUMP_FLAG_PARITY_EN
   logic        parity_q, parity_d;
`endif

   jump_flag_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (valid_i),
      .pop_i   (fifo_pop),
      .din_i   (data_i),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign ready_o   = !fifo_full;
   assign baud_wrap = (baud_q == BAUD_LAST);

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_wrap ? '0 : baud_q + 16'd1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (baud_wrap) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (baud_wrap) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef JUMP_FLAG_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef JUMP_FLAG_PARITY_EN
         ST_PARITY: begin
            if (baud_wrap) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            // Chaining straight into START keeps queued frames gap-free.
            if (baud_wrap) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  state_d  = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase
      if (fifo_pop) shift_d = fifo_dout;
   end

   always_comb begin
      tx_d = LINE_IDLE;
      case (state_q)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_q[0];
`ifdef JUMP_FLAG_PARITY_EN
         ST_PARITY: tx_d = parity_q;
`endif
         default:  tx_d = LINE_IDLE;
      endcase
   end

   assign busy_d = (state_q != ST_IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= LINE_IDLE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

`ifdef JUMP_FLAG_PARITY_EN
   assign parity_d = fifo_pop ? even_parity(fifo_dout) : parity_q;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) parity_q <= 1'b0;
      else                  parity_q <= parity_d;
   end
`endif

   assign tx_o   = tx_q;
   assign busy_o = busy_q;

endmodule

// File: tb/tb_jump_flag_serializer.sv
// Bench for jump_flag_serializer (BIT_CYCLES=4, FIFO_DEPTH=4); honours JUMP_FLAG_PARITY_EN.
module tb_jump_flag_serializer;

   localparam int BC    = 4;
   localparam int DEPTH = 4;
`ifdef JUMP_FLAG_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FRAME = FB * BC;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid_i = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic       ready_o;
   logic       tx_o;
   logic       busy_o;

   jump_flag_serializer #(
      .BIT_CYCLES (BC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid_i),
      .data_i  (data_i),
      .ready_o (ready_o),
      .tx_o    (tx_o),
      .busy_o  (busy_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   logic [7:0] sb[$];
   int         starts_q[$];

   typedef struct {
      logic [7:0]  data;
      logic [9:0]  exp10;   // line bits in send order, bit 0 first
      logic [10:0] exp11;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after a posedge; returns just after the accept edge.
   task automatic send_one(input logic [7:0] b, output logic acc);
      valid_i = 1'b1;
      data_i  = b;
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      if (acc) sb.push_back(b);
   endtask

   // Line monitor: decodes every frame and scores it against the expected queue.
   task automatic capture_frame();
      logic [10:0] bits;
      int          hold_bad;
      logic        aborted;
      logic [7:0]  exp_b;
      bits     = '0;
      bits[0]  = tx_o;
      hold_bad = 0;
      aborted  = 1'b0;
      starts_q.push_back(cyc);
      for (int s = 1; s < FB * BC; s++) begin
         @(negedge clk);
         if (rst) aborted = 1'b1;
         if (s % BC == 0) bits[s / BC] = tx_o;
         else if (tx_o !== bits[s / BC]) hold_bad++;
      end
      if (!aborted) begin
         chk("bit_hold", 32'(hold_bad), 0);
         chk("start_bit", 32'(bits[0]), 0);
         chk("stop_bit", 32'(bits[FB-1]), 1);
         chk("sb_nonempty", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            exp_b = sb.pop_front();
            chk("sb_data", 32'(bits[8:1]), 32'(exp_b));
`ifdef JUMP_FLAG_PARITY_EN
            chk("parity_bit", 32'(bits[9]), 32'(^exp_b));
`endif
         end
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst == 1'b0 && tx_o == 1'b0) capture_frame();
      end
   end

   initial begin : main
      logic        acc;
      logic [10:0] exp_bits;
      logic        exp_tx, exp_busy, tx_k1, tx_k2, ready5, r;
      int          bad_tx, bad_busy, idx, rise_it, bad;
      int          acc_it[6];
      logic [7:0]  b6[6];

      vecs[0] = '{8'hA5, 10'b1101001010, 11'b10101001010};
      vecs[1] = '{8'h01, 10'b1000000010, 11'b11000000010};
      vecs[2] = '{8'h00, 10'b1000000000, 11'b10000000000};
      vecs[3] = '{8'hFF, 10'b1111111110, 11'b10111111110};
      vecs[4] = '{8'h3C, 10'b1001111000, 11'b10001111000};
      vecs[5] = '{8'h80, 10'b1100000000, 11'b11100000000};

      // Reset state, held idle for 20 cycles.
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("rst_tx", 32'(tx_o), 1);
         chk("rst_busy", 32'(busy_o), 0);
         chk("rst_ready", 32'(ready_o), 1);
      end
      tick();

      // Single bytes: exact line waveform and busy window against the table.
      foreach (vecs[v]) begin
`ifdef JUMP_FLAG_PARITY_EN
         exp_bits = vecs[v].exp11;
`else
         exp_bits = {1'b0, vecs[v].exp10};
`endif
         repeat (3) tick();
         send_one(vecs[v].data, acc);
         chk("single_accept", 32'(acc), 1);
         bad_tx = 0;
         bad_busy = 0;
         tx_k1 = 1'bx;
         tx_k2 = 1'bx;
         for (int k = 0; k <= FRAME + 2; k++) begin
            @(negedge clk);
            exp_tx   = (k < 2 || k > FRAME + 1) ? 1'b1 : exp_bits[(k - 2) / BC];
            exp_busy = (k >= 1 && k <= FRAME + 1);
            if (tx_o !== exp_tx) bad_tx++;
            if (busy_o !== exp_busy) bad_busy++;
            if (k == 1) tx_k1 = tx_o;
            if (k == 2) tx_k2 = tx_o;
         end
         chk("tx_high_after_accept", 32'(tx_k1), 1);
         chk("tx_fall_at_n_plus_2", 32'(tx_k2), 0);
         chk("frame_bits", 32'(bad_tx), 0);
         chk("busy_window", 32'(bad_busy), 0);
         tick();
      end

      // Burst with continuous valid: fill, hold the sixth byte, pop-while-full.
      repeat (4) tick();
      starts_q.delete();
      b6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      foreach (acc_it[i]) acc_it[i] = -1;
      idx = 0;
      rise_it = -1;
      ready5 = 1'bx;
      valid_i = 1'b1;
      data_i = b6[0];
      for (int it = 0; it < 400 && idx < 6; it++) begin
         @(negedge clk);
         r = ready_o;
         if (idx == 5 && it == 5) ready5 = r;
         if (idx == 5 && r && rise_it < 0) rise_it = it;
         @(posedge clk);
         #1;
         if (r) begin
            sb.push_back(b6[idx]);
            acc_it[idx] = it;
            idx++;
            if (idx < 6) data_i = b6[idx];
            else valid_i = 1'b0;
         end
      end
      valid_i = 1'b0;
      chk("burst_accepted", 32'(idx), 6);
      chk("burst_0x55_no_wait", 32'(acc_it[4]), 4);
      chk("ready_low_when_full", 32'(ready5), 0);
      chk("ready_rise_after_pop", 32'(rise_it), 32'(FRAME + 2));
      chk("held_byte_accept", 32'(acc_it[5]), 32'(FRAME + 2));
      for (int i = 0; i < 8 * FRAME && busy_o !== 1'b0; i++) @(negedge clk);
      chk("burst_drain", 32'(busy_o), 0);
      chk("burst_frame_count", 32'(starts_q.size()), 6);
      for (int i = 1; i < starts_q.size(); i++)
         chk("burst_frame_gap", 32'(starts_q[i] - starts_q[i-1]), 32'(FRAME));
      tick();
      chk("burst_sb_drained", 32'(sb.size()), 0);

      // Reset in the middle of the 0xF0 data bits with two bytes queued.
      repeat (3) tick();
      send_one(8'hF0, acc);
      send_one(8'hAA, acc);
      send_one(8'hBB, acc);
      repeat (3 * BC) tick();
      @(negedge clk);
      chk("pre_reset_busy", 32'(busy_o), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_tx", 32'(tx_o), 1);
      chk("midrst_busy", 32'(busy_o), 0);
      chk("midrst_ready", 32'(ready_o), 1);
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      starts_q.delete();
      bad = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clk);
         if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
      end
      chk("post_reset_quiet", 32'(bad), 0);
      chk("post_reset_frames", 32'(starts_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
